// File: rtl/rv_pkg.sv
// Shared RV32 constants and types for the fetch slice.
package rv_pkg;
  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RV_NOP_INSTR = 32'h0000_0013; // addi x0,x0,0
  localparam logic [XLEN-1:0] RV_RESET_PC  = 32'h0000_0000;

  // Fetch FSM: request outstanding / word parked for stalled decode / stale request in flight
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_HOLD = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  // Instruction field positions
  localparam int OP_LSB = 0;
  localparam int OP_W   = 7;
  localparam int F3_LSB = 12;
  localparam int F3_W   = 3;
  localparam int F7_LSB = 25;
  localparam int F7_W   = 7;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_word_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return a & ~(XLEN'(3));
  endfunction
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, drops to a NOP bubble on flush or when empty.
module if_id_reg
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load_valid,
  input  fetch_word_t     load_word,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // An empty register accepts even under stall so a bubble never blocks fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (!stall || !valid) begin
      valid <= load_valid;
      instr <= load_valid ? load_word.instr : NOP_INSTR;
      if (load_valid) pc <= load_word.pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem request, a one-entry skid for decode
// stalls, and redirect handling that discards a request already in flight.
module fetch_stage
  import rv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RV_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INSTR = RV_NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic [OP_W-1:0] op_d,
  output logic [F3_W-1:0] funct3_d,
  output logic [F7_W-1:0] funct7_d
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f;     // next address to fetch (redirect target while dropping)
  logic [XLEN-1:0] addr_q;   // address currently on the imem bus
  fetch_word_t     skid_q;
  logic            accept;   // IF/ID can take a word this cycle
  logic            if_load_valid;
  fetch_word_t     if_load_word;
  logic [XLEN-1:0] redir_addr;

  assign accept     = !stall_d || !valid_d;
  assign redir_addr = align_word(redirect_pc);
  assign imem_addr  = addr_q;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FS_REQ;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FS_REQ: begin
        if (redirect_valid)         state_d = imem_ack ? FS_REQ : FS_DROP;
        else if (imem_ack && !accept) state_d = FS_HOLD;
      end
      FS_HOLD: if (redirect_valid || accept) state_d = FS_REQ;
      FS_DROP: if (imem_ack)                 state_d = FS_REQ;
      default: state_d = FS_REQ;
    endcase
  end

  // FSM outputs: bus request and the word offered to IF/ID
  always_comb begin
    imem_req      = !rst && (state_q != FS_HOLD);
    if_load_valid = 1'b0;
    if_load_word  = '{instr: imem_rdata, pc: addr_q};
    unique case (state_q)
      FS_REQ:  if_load_valid = imem_ack && !redirect_valid;
      FS_HOLD: begin
        if_load_valid = !redirect_valid;
        if_load_word  = skid_q;
      end
      default: if_load_valid = 1'b0;
    endcase
  end

  // PC, bus address and skid. A flush without redirect still lets the FSM
  // advance: the word handed over that cycle is younger than the killed one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f   <= RESET_PC;
      addr_q <= RESET_PC;
      skid_q <= '0;
    end else if (redirect_valid) begin
      // Skid contents become dead once the FSM leaves HOLD; no need to clear.
      pc_f <= redir_addr;
      if (state_q == FS_HOLD || imem_ack) addr_q <= redir_addr;
    end else begin
      unique case (state_q)
        FS_REQ: begin
          if (imem_ack) begin
            if (accept) begin
              pc_f   <= pc_f + 32'd4;
              addr_q <= pc_f + 32'd4;
            end else begin
              skid_q <= '{instr: imem_rdata, pc: addr_q};
            end
          end
        end
        FS_HOLD: begin
          if (accept) begin
            pc_f   <= pc_f + 32'd4;
            addr_q <= pc_f + 32'd4;
          end
        end
        FS_DROP: if (imem_ack) addr_q <= pc_f;
        default: ;
      endcase
    end
  end

  if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall_d),
    .flush      (flush_d || redirect_valid),
    .load_valid (if_load_valid),
    .load_word  (if_load_word),
    .valid      (valid_d),
    .instr      (instr_d),
    .pc         (pc_d)
  );

  assign pc_plus4_d = pc_d + 32'd4;
  assign op_d       = instr_d[OP_LSB +: OP_W];
  assign funct3_d   = instr_d[F3_LSB +: F3_W];
  assign funct7_d   = instr_d[F7_LSB +: F7_W];

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timeline checks plus a randomized run
// checked against an address-stream/memory-content reference model.
module tb_fetch_stage;
  import rv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_d = 1'b0, flush_d = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req, imem_ack = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        valid_d;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic [6:0]  op_d, funct7_d;
  logic [2:0]  funct3_d;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_d(stall_d), .flush_d(flush_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .valid_d(valid_d), .instr_d(instr_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .op_d(op_d),
    .funct3_d(funct3_d), .funct7_d(funct7_d)
  );

  int          ntests = 0, nfail = 0;
  int          mem_lat = 1, wcnt = 0;
  bit          junk_en = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;

  // Memory contents: a fixed function of the word address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Memory responder: ack on the mem_lat-th cycle of a request
  task automatic drive_mem();
    if (imem_req) begin
      if (wcnt >= mem_lat - 1) begin
        imem_ack = 1'b1; imem_rdata = memf(imem_addr); wcnt = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; wcnt++;
      end
    end else begin
      wcnt = 0;
      imem_ack = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      imem_rdata = $urandom;
    end
  endtask

  // Drive one cycle of inputs from a negedge, return at the next negedge
  task automatic cyc(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    stall_d = st; flush_d = fl; redirect_valid = rv; redirect_pc = rpc;
    #1;
    drive_mem();
    pend  = imem_req && !imem_ack;
    paddr = imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc);
    logic [31:0] w;
    chk1({tag, "_valid"}, valid_d, ev);
    if (ev) begin
      w = memf(epc);
      chk({tag, "_pc"}, pc_d, epc);
      chk({tag, "_instr"}, instr_d, w);
    end else begin
      chk({tag, "_nop"}, instr_d, NOP);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_lat = 1; junk_en = 1'b0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk1("rst_req", imem_req, 1'b0);
    chk1("rst_valid", valid_d, 1'b0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc", pc_d, 32'h0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] w, exp_pc;
    int consumed;

    // Zero-wait streaming: pc_d 0,4,8,12
    do_reset();
    chk1("zw_req0", imem_req, 1'b1);
    chk("zw_addr0", imem_addr, 32'h0);
    chk1("zw_valid0", valid_d, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0);
      chk_out("zw", 1'b1, 32'((k - 1) * 4));
      w = memf(32'((k - 1) * 4));
      chk("zw_op", 32'(op_d), 32'(w[6:0]));
      chk("zw_f3", 32'(funct3_d), 32'(w[14:12]));
      chk("zw_f7", 32'(funct7_d), 32'(w[31:25]));
      chk("zw_pc4", pc_plus4_d, 32'(k * 4));
    end

    // Stall for 4 cycles: hold pc 12, no requests, then 16, 20 in order
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 0, 0);
      chk_out("stall_hold", 1'b1, 32'd12);
      chk1("stall_noreq", imem_req, 1'b0);
    end
    cyc(0, 0, 0, 0); chk_out("stall_rel0", 1'b1, 32'd16);
    cyc(0, 0, 0, 0); chk_out("stall_rel1", 1'b1, 32'd20);

    // Latency 3: address held 3 cycles, one instruction every 3 cycles
    do_reset();
    mem_lat = 3;
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 0);
      chk("lat3_addr", imem_addr, 32'((k / 3) * 4));
      chk_out("lat3", (k % 3) == 0, 32'((k / 3 - 1) * 4));
    end

    // Redirect while ack pending: stale word dropped, refetch at 0x100
    do_reset();
    mem_lat = 3;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h0000_0102);
    chk("drop_addr_held", imem_addr, 32'h0);
    chk1("drop_req", imem_req, 1'b1);
    chk_out("drop_c2", 1'b0, 32'h0);
    cyc(0, 0, 0, 0);
    chk_out("drop_stale", 1'b0, 32'h0);
    chk("drop_newaddr", imem_addr, 32'h0000_0100);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_out("drop_c5", 1'b0, 32'h0);
    cyc(0, 0, 0, 0);
    chk_out("drop_target", 1'b1, 32'h0000_0100);

    // Flush together with stall: bubble now, parked word delivered after
    do_reset();
    cyc(0, 0, 0, 0);
    chk_out("fs_pre", 1'b1, 32'h0);
    cyc(1, 1, 0, 0);
    chk_out("fs_kill", 1'b0, 32'h0);
    chk("fs_op", 32'(op_d), 32'h13);
    cyc(0, 0, 0, 0);
    chk_out("fs_after", 1'b1, 32'h4);

    // Reset during HOLD
    do_reset();
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk1("rh_hold_noreq", imem_req, 1'b0);
    rst = 1'b1;
    cyc(1, 0, 0, 0);
    chk1("rh_valid", valid_d, 1'b0);
    chk("rh_instr", instr_d, NOP);
    chk("rh_pc", pc_d, 32'h0);
    chk1("rh_req", imem_req, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rh_req_restart", imem_req, 1'b1);
    chk("rh_addr_restart", imem_addr, 32'h0);
    cyc(0, 0, 0, 0);
    chk_out("rh_first", 1'b1, 32'h0);

    // PC wrap at the top of the address space
    do_reset();
    cyc(0, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk1("wrap_valid0", valid_d, 1'b0);
    cyc(0, 0, 0, 0);
    chk_out("wrap", 1'b1, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc_plus4_d, 32'h0);
    chk("wrap_next_addr", imem_addr, 32'h0);

    // Randomized run: every word decode takes must be the next address in
    // program order (restarting at each redirect target) with matching data
    do_reset();
    junk_en  = 1'b1;
    exp_pc   = 32'h0;
    consumed = 0;
    for (int n = 0; n < 3000; n++) begin
      logic        st, rv;
      logic [31:0] rpc;
      if (valid_d) chk("rnd_instr", instr_d, memf(pc_d));
      else         chk("rnd_nop", instr_d, NOP);
      if (pend) begin
        chk("rnd_addr_hold", imem_addr, paddr);
        chk1("rnd_req_hold", imem_req, 1'b1);
      end
      chk("rnd_align", imem_addr & 32'd3, 32'h0);
      st  = ($urandom % 10) < 3;
      rv  = ($urandom % 20) == 0;
      rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      if (($urandom % 50) == 0) mem_lat = $urandom_range(1, 3);
      if (valid_d && !st && !rv) begin
        chk("rnd_order", pc_d, exp_pc);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (rv) exp_pc = rpc & ~32'd3;
      cyc(st, 0, rv, rpc);
    end
    chk1("rnd_progress", consumed > 300, 1'b1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
